relu_maxpool: RTL and testbench

//  Downstream stage of the convolver. Consumes the convolver's raster-ordered output stream (conv_op/valid_conv).

---
 rtl/relu_maxpool.sv | 95 +++++++++
 tb/tb_relu_maxpool.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool.sv
// relu_maxpool: optional ReLU followed by 2x2/stride-2 max pooling over a
// raster-ordered M x M conv output stream. A half-row line buffer holds the
// horizontal maxima of each even row until the matching odd row arrives.
module relu_maxpool #(
  parameter int M    = 8,   // conv map width = height
  parameter int N    = 16,  // data width, two's complement
  parameter int Q    = 12,  // fractional bits, carried through untouched
  parameter int RELU = 1    // 1: clamp negatives to zero before pooling
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         ce,
  input  logic [N-1:0] conv_in,
  input  logic         conv_valid,
  output logic [N-1:0] pool_out,
  output logic         pool_valid,
  output logic         pool_end
);

  // Counters need at least 2 bits so col[CW-1:1] is always a legal slice.
  localparam int CW   = (M > 2) ? $clog2(M) : 2;
  localparam int HALF = M / 2;
  localparam int LBD  = 1 << (CW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);
  // Last row/col that closes a window; differs from COL_LAST for odd M.
  localparam logic [CW-1:0] WIN_LAST = CW'(2 * HALF - 1);

  if (M < 2 || Q >= N) begin : g_bad_param
    $error("relu_maxpool: need M >= 2 and Q < N");
  end

  typedef struct packed {
    logic [N-1:0] data;
    logic         vld;
    logic         last;
  } pool_rsp_t;

  logic [CW-1:0]       col, row;
  logic signed [N-1:0] hmax, x, h, lb_rd, v;
  logic [N-1:0]        lb [LBD];
  logic [CW-2:0]       lb_idx;
  logic                accept, fire;
  pool_rsp_t           rsp;

  assign accept = ce & conv_valid;
  assign x      = ((RELU != 0) && conv_in[N-1]) ? '0 : conv_in;
  assign h      = (x > hmax) ? x : hmax;
  assign lb_idx = col[CW-1:1];
  assign lb_rd  = lb[lb_idx];
  assign v      = (h > lb_rd) ? h : lb_rd;
  // Odd row and odd col always lie inside a complete window, even for odd M.
  assign fire   = accept & row[0] & col[0];

  // Raster position of the next accepted sample; wraps per row and per frame.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == COL_LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Left half of the current horizontal pair.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) hmax <= '0;
    else if (accept && !col[0]) hmax <= x;
  end

  // Even-row horizontal maxima, consumed by the odd row below; no reset needed.
  always_ff @(posedge clk) begin
    if (accept && !row[0] && col[0]) lb[lb_idx] <= h;
  end

  // Pooled result register; pulses last one ce cycle and hold while ce is low.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      rsp <= '0;
    end else if (ce) begin
      rsp.vld  <= fire;
      rsp.last <= fire && (row == WIN_LAST) && (col == WIN_LAST);
      if (fire) rsp.data <= v;
    end
  end

  assign pool_out   = rsp.data;
  assign pool_valid = rsp.vld;
  assign pool_end   = rsp.last;

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench: three DUT configurations (M4/ReLU, M4/raw, M5/raw) share
// one randomized input stream; a frame-array reference model predicts each
// pooled value and the ce cycle on which it must appear.
module tb_relu_maxpool;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        conv_valid;
  logic [15:0] conv_in;
  logic [15:0] po [3];
  logic        pv [3];
  logic        pe [3];

  int checks = 0;
  int errors = 0;
  int mcyc   = 0;
  int ncyc   = 0;

  typedef struct {
    logic signed [15:0] v;
    logic               e;
    int                 cyc;
  } exp_t;

  exp_t               q  [3][$];
  logic signed [15:0] fr [3][25];
  int                 kk [3];

  always #5 clk = ~clk;

  relu_maxpool #(.M(4), .N(16), .Q(12), .RELU(1)) u_m4r (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(conv_in),
    .conv_valid(conv_valid), .pool_out(po[0]), .pool_valid(pv[0]), .pool_end(pe[0]));
  relu_maxpool #(.M(4), .N(16), .Q(12), .RELU(0)) u_m4 (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(conv_in),
    .conv_valid(conv_valid), .pool_out(po[1]), .pool_valid(pv[1]), .pool_end(pe[1]));
  relu_maxpool #(.M(5), .N(16), .Q(12), .RELU(0)) u_m5 (
    .clk(clk), .global_rst_n(rst_n), .ce(ce), .conv_in(conv_in),
    .conv_valid(conv_valid), .pool_out(po[2]), .pool_valid(pv[2]), .pool_end(pe[2]));

  function automatic int m_of(input int i);
    return (i == 2) ? 5 : 4;
  endfunction

  function automatic bit relu_of(input int i);
    return (i == 0);
  endfunction

  // Store the sample at its (row,col) in a frame image; when it closes a
  // 2x2 window, the expected output is the max of the four stored samples.
  task automatic model_accept(input int i, input logic signed [15:0] din);
    int m, r, c, hh;
    logic signed [15:0] xv, mx, s;
    exp_t t;
    m  = m_of(i);
    hh = m / 2;
    xv = (relu_of(i) && din < 0) ? 16'sd0 : din;
    fr[i][kk[i]] = xv;
    r = kk[i] / m;
    c = kk[i] % m;
    if (r % 2 == 1 && c % 2 == 1 && r < 2 * hh && c < 2 * hh) begin
      mx = fr[i][(r - 1) * m + c - 1];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          s = fr[i][(r - 1 + dr) * m + c - 1 + dc];
          if (s > mx) mx = s;
        end
      t.v = mx;
      t.e = (r == 2 * hh - 1) && (c == 2 * hh - 1);
      t.cyc = mcyc + 1;
      q[i].push_back(t);
    end
    kk[i] = (kk[i] + 1) % (m * m);
  endtask

  // Reference model: observes accepted samples and queues expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        kk[i] = 0;
        q[i].delete();
      end
    end else if (ce && conv_valid) begin
      for (int i = 0; i < 3; i++) model_accept(i, $signed(conv_in));
    end
    if (ce) mcyc++;
  end

  task automatic check_inst(input int i);
    exp_t t;
    if (pv[i]) begin
      checks++;
      if (q[i].size() == 0) begin
        errors++;
        $display("FAIL unexpected_out inst%0d got %0d end=%0d, required no output", i, $signed(po[i]), pe[i]);
      end else begin
        t = q[i].pop_front();
        if ($signed(po[i]) !== t.v || pe[i] !== t.e || ncyc != t.cyc)
          begin
            errors++;
            $display("FAIL pool_out inst%0d got %0d end=%0d cyc=%0d, required %0d end=%0d cyc=%0d",
                     i, $signed(po[i]), pe[i], ncyc, t.v, t.e, t.cyc);
          end
      end
    end else begin
      if (pe[i]) begin
        checks++;
        errors++;
        $display("FAIL end_without_valid inst%0d got pool_end=1, required 0", i);
      end
      if (q[i].size() > 0 && q[i][0].cyc <= ncyc) begin
        t = q[i].pop_front();
        checks++;
        errors++;
        $display("FAIL missing_out inst%0d got no pool_valid, required %0d at cyc %0d", i, t.v, t.cyc);
      end
    end
  endtask

  // Monitor: each result is counted once, on the ce cycle it is consumed.
  always @(negedge clk) begin
    if (ce && rst_n)
      for (int i = 0; i < 3; i++) check_inst(i);
    if (ce) ncyc++;
  end

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (po[i] !== 16'd0 || pv[i] !== 1'b0 || pe[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d got out=%0d vld=%0d end=%0d, required 0 0 0",
                 tag, i, po[i], pv[i], pe[i]);
      end
    end
  endtask

  task automatic send(input logic [15:0] v, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    for (int j = 0; j < g; j++) begin
      ce         = 1'($urandom_range(0, 1));
      conv_valid = ce ? 1'b0 : 1'($urandom_range(0, 1));
      conv_in    = 16'($urandom);
      @(posedge clk); #1;
    end
    ce = 1'b1; conv_valid = 1'b1; conv_in = v;
    @(posedge clk); #1;
    conv_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 check_cleared("reset_clear");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_seq(input int base, input int cnt, input int maxgap);
    for (int j = 1; j <= cnt; j++) send(16'(base + j), maxgap);
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; conv_valid = 1'b0; conv_in = '0;
    #2 check_cleared("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // M=5 frame 1..25 (floor pooling); M=4 instances see 1..16 plus a partial.
    send_seq(0, 25, 0);
    send_seq(0, 16, 0);
    do_reset();
    // Contiguous 1..16, then -5 everywhere except sample 6 = 3.
    send_seq(0, 16, 0);
    for (int j = 1; j <= 16; j++) send((j == 6) ? 16'sd3 : -16'sd5, 0);
    // Back-to-back frames.
    send_seq(0, 16, 0);
    send_seq(100, 16, 0);
    // Gaps and ce-low bursts.
    send_seq(0, 16, 3);
    // Reset after 7 accepts, then a clean frame.
    do_reset();
    send_seq(0, 7, 1);
    do_reset();
    send_seq(0, 16, 0);
    // Random signed data with random gaps.
    for (int j = 0; j < 80; j++) send(16'($urandom), 3);

    ce = 1'b1; conv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL leftover inst%0d got %0d pending, required 0", i, q[i].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish, required finish by 500000");
    $fatal(1, "timeout");
  end

endmodule
